// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart TX FIFO between NUM_REQ byte-stream
// clients, with an idle watchdog that reclaims the grant from a client stalled mid-packet.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       uart_tx_fifo_full,
    output logic                       uart_tx_start,
    output logic [7:0]                 uart_tx_data_in,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err,
    output logic [$clog2(NUM_REQ)-1:0] timeout_id
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam bit WD_EN = (IDLE_TIMEOUT > 0);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state_q,       state_d;
    logic [ID_W-1:0]  grant_id_q,    grant_id_d;
    logic [ID_W-1:0]  last_grant_q,  last_grant_d;
    logic [CNT_W-1:0] idle_cnt_q,    idle_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic [ID_W-1:0]  timeout_id_q,  timeout_id_d;

    logic             g_valid;
    logic             g_last;
    logic [7:0]       g_data;
    logic             pick_found;
    logic [ID_W-1:0]  pick_id;

    // Signals of the currently granted client; everyone else is ignored.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[8*i +: 8];
            end
        end
    end

    // Round-robin pick: first valid requester after last_grant, wrapping modulo NUM_REQ.
    always_comb begin : rr_pick
        int              cand;
        logic [ID_W-1:0] cand_id;
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = 0;
        cand_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand    = (int'(last_grant_q) + k) % NUM_REQ;
            cand_id = ID_W'(cand);
            if (!pick_found && req_valid[cand_id]) begin
                pick_found = 1'b1;
                pick_id    = cand_id;
            end
        end
    end

    // Accept and push share one cycle, so a push never lands in a full FIFO.
    always_comb begin
        req_ready       = '0;
        uart_tx_start   = 1'b0;
        uart_tx_data_in = 8'h00;
        if (state_q == ST_GRANT) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (grant_id_q == ID_W'(i)) && !uart_tx_fifo_full;
            end
            uart_tx_start   = g_valid && !uart_tx_fifo_full;
            uart_tx_data_in = g_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = 1'b0;
        timeout_id_d  = timeout_id_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_GRANT;
                    grant_id_d = pick_id;
                    idle_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (uart_tx_start && g_last) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_id_q;
                    idle_cnt_d   = '0;
                end else if (g_valid) begin
                    idle_cnt_d = '0;
                end else if (WD_EN && !uart_tx_fifo_full) begin
                    // A full FIFO holds the count: back-pressure is never the client's stall.
                    if (idle_cnt_q == CNT_LAST) begin
                        state_d       = ST_IDLE;
                        last_grant_d  = grant_id_q;
                        idle_cnt_d    = '0;
                        timeout_err_d = 1'b1;
                        timeout_id_d  = grant_id_q;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_id_q    <= '0;
            last_grant_q  <= ID_LAST;
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            timeout_id_q  <= '0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
            timeout_id_q  <= timeout_id_d;
        end
    end

    assign grant_valid = (state_q == ST_GRANT);
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;
    assign timeout_id  = timeout_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 clients, watchdog shortened to 8 cycles).
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0] req_last;
    logic [N-1:0] req_ready;
    logic         uart_tx_fifo_full;
    logic         uart_tx_start;
    logic [7:0]   uart_tx_data_in;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         timeout_err;
    logic [1:0]   timeout_id;

    int n_checks = 0;
    int n_fail   = 0;

    // Packet engine state for the multi-client scenarios.
    int pkts_left[N];
    int pkt_no[N];
    int byte_idx[N];
    int pkt_len[N];
    int cyc;
    logic [7:0] push_data[$];
    logic [1:0] push_gid[$];
    int         push_cyc[$];

    uart_tx_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .uart_tx_fifo_full(uart_tx_fifo_full),
        .uart_tx_start    (uart_tx_start),
        .uart_tx_data_in  (uart_tx_data_in),
        .grant_valid      (grant_valid),
        .grant_id         (grant_id),
        .timeout_err      (timeout_err),
        .timeout_id       (timeout_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid         = '0;
        req_data          = '0;
        req_last          = '0;
        uart_tx_fifo_full = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [7:0] byte_val(input int c, input int p, input int b);
        return 8'((c << 6) | (p * 2 + b));
    endfunction

    task automatic drive_clients();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (pkts_left[i] > 0);
            req_data[8*i +: 8] = byte_val(i, pkt_no[i], byte_idx[i]);
            req_last[i]        = (byte_idx[i] == pkt_len[i] - 1);
        end
    endtask

    task automatic engine_cycle();
        logic [N-1:0] acc;
        acc = req_valid & req_ready;
        if (uart_tx_start) begin
            push_data.push_back(uart_tx_data_in);
            push_gid.push_back(grant_id);
            push_cyc.push_back(cyc);
        end
        step();
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                byte_idx[i]++;
                if (byte_idx[i] == pkt_len[i]) begin
                    byte_idx[i] = 0;
                    pkt_no[i]++;
                    pkts_left[i]--;
                end
            end
        end
        drive_clients();
        #1;
    endtask

    task automatic run_engine(input string tag, input int budget);
        int n;
        bit busy;
        n = 0;
        cyc = 0;
        push_data.delete();
        push_gid.delete();
        push_cyc.delete();
        drive_clients();
        #1;
        busy = 1'b1;
        while (busy && n < budget) begin
            engine_cycle();
            n++;
            busy = 1'b0;
            for (int i = 0; i < N; i++) if (pkts_left[i] > 0) busy = 1'b1;
        end
        check({tag, "_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int bad;
        int cnt[N];
        int order[3];

        clear_inputs();
        rst_n = 1'b0;
        req_valid = 4'hF;
        step();
        step();
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_timeout_id", timeout_id, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_start", uart_tx_start, 0);
        check("rst_tx_data", uart_tx_data_in, 0);
        clear_inputs();
        rst_n = 1'b1;
        #1;

        // Single client 1, three bytes 0x41..0x43.
        req_valid[1] = 1'b1;
        req_data[15:8] = 8'h41;
        #1;
        check("t1_idle_no_start", uart_tx_start, 0);
        check("t1_idle_no_grant", grant_valid, 0);
        step();
        check("t1_grant_valid", grant_valid, 1);
        check("t1_grant_id", grant_id, 1);
        check("t1_ready", req_ready, 4'b0010);
        for (int b = 0; b < 3; b++) begin
            req_data[15:8] = 8'h41 + 8'(b);
            req_last[1]    = (b == 2);
            #1;
            check("t1_start", uart_tx_start, 1);
            check("t1_data", uart_tx_data_in, 32'h41 + 32'(b));
            step();
        end
        req_valid[1] = 1'b0;
        req_last[1]  = 1'b0;
        #1;
        check("t1_release", grant_valid, 0);
        check("t1_no_start_after", uart_tx_start, 0);

        // Clients 0,2,3 with 2-byte packets from reset: order 0,2,3, one idle cycle between.
        do_reset();
        for (int i = 0; i < N; i++) begin
            pkts_left[i] = (i == 1) ? 0 : 1;
            pkt_no[i] = 0;
            byte_idx[i] = 0;
            pkt_len[i] = 2;
        end
        run_engine("t2", 60);
        check("t2_push_count", push_data.size(), 6);
        order[0] = 0; order[1] = 2; order[2] = 3;
        for (int k = 0; k < 6 && k < push_data.size(); k++) begin
            check("t2_data", push_data[k], byte_val(order[k/2], 0, k%2));
            check("t2_gid", push_gid[k], order[k/2]);
            if (k > 0) check("t2_gap", push_cyc[k] - push_cyc[k-1], (k % 2 == 1) ? 1 : 2);
        end
        clear_inputs();

        // FIFO full for 50 cycles mid-packet: no push, no timeout, resume on release.
        do_reset();
        req_valid[0] = 1'b1;
        req_data[7:0] = 8'h10;
        step();
        check("t3_grant_id", grant_id, 0);
        check("t3_start0", uart_tx_start, 1);
        check("t3_data0", uart_tx_data_in, 8'h10);
        step();
        req_data[7:0] = 8'h11;
        uart_tx_fifo_full = 1'b1;
        #1;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            if (req_ready != 0 || uart_tx_start || timeout_err || !grant_valid) bad++;
            step();
        end
        check("t3_full_bad_cycles", bad, 0);
        uart_tx_fifo_full = 1'b0;
        #1;
        check("t3_resume_ready", req_ready, 4'b0001);
        check("t3_resume_start", uart_tx_start, 1);
        check("t3_resume_data", uart_tx_data_in, 8'h11);
        step();
        req_data[7:0] = 8'h12;
        req_last[0] = 1'b1;
        #1;
        check("t3_last_data", uart_tx_data_in, 8'h12);
        step();
        clear_inputs();
        #1;
        check("t3_release", grant_valid, 0);

        // Watchdog: client 2 stalls after one byte; client 3 waiting.
        do_reset();
        req_valid[2] = 1'b1;
        req_data[23:16] = 8'h22;
        req_valid[3] = 1'b1;
        req_data[31:24] = 8'h33;
        req_last[3] = 1'b1;
        step();
        check("t4_grant_id", grant_id, 2);
        check("t4_data", uart_tx_data_in, 8'h22);
        step();
        req_valid[2] = 1'b0;
        #1;
        n = 0;
        while (!timeout_err && n < 20) begin
            step();
            n++;
        end
        check("t4_timeout_cycles", n, 8);
        check("t4_timeout_err", timeout_err, 1);
        check("t4_timeout_id", timeout_id, 2);
        check("t4_grant_dropped", grant_valid, 0);
        step();
        check("t4_pulse_once", timeout_err, 0);
        check("t4_next_grant_valid", grant_valid, 1);
        check("t4_next_grant_id", grant_id, 3);
        check("t4_timeout_id_held", timeout_id, 2);
        check("t4_next_data", uart_tx_data_in, 8'h33);
        step();
        clear_inputs();
        #1;
        check("t4_release", grant_valid, 0);

        // Fairness: all four continuously valid, 10 one-byte packets each.
        do_reset();
        for (int i = 0; i < N; i++) begin
            pkts_left[i] = 10;
            pkt_no[i] = 0;
            byte_idx[i] = 0;
            pkt_len[i] = 1;
            cnt[i] = 0;
        end
        run_engine("t5", 200);
        check("t5_push_count", push_data.size(), 40);
        for (int k = 0; k < push_data.size() && k < 40; k++) begin
            check("t5_data", push_data[k], byte_val(k % 4, k / 4, 0));
            cnt[push_gid[k]]++;
            if (k > 0) check("t5_gap", push_cyc[k] - push_cyc[k-1], 2);
        end
        for (int i = 0; i < N; i++) check("t5_grants_per_client", cnt[i], 10);
        clear_inputs();

        // Async reset mid-packet; last_grant must return to NUM_REQ-1.
        do_reset();
        req_valid[0] = 1'b1;
        req_data[7:0] = 8'h55;
        req_last[0] = 1'b1;
        step();
        step();
        clear_inputs();
        req_valid[1] = 1'b1;
        req_data[15:8] = 8'h61;
        step();
        check("t6_grant_id", grant_id, 1);
        check("t6_start", uart_tx_start, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_grant_valid", grant_valid, 0);
        check("t6_async_start", uart_tx_start, 0);
        check("t6_async_ready", req_ready, 0);
        check("t6_async_data", uart_tx_data_in, 0);
        clear_inputs();
        step();
        rst_n = 1'b1;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        req_last = 4'b1001;
        step();
        check("t6_restart_grant_id", grant_id, 0);
        check("t6_restart_grant_valid", grant_valid, 1);
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
